// File: rtl/posta_pkg.sv
`default_nettype none
// ============================================================================
// Module   : posta_pkg
// Purpose  : Shared constants and types for the Winograd F(2x2,3x3)
//            post-transform tile unit: A^T coefficients, input FIFO depth,
//            channel-index type and the 4x4 accumulator tile type.
// Revision : 1.0  initial release
// ============================================================================
package posta_pkg;

  // Default accumulator width used for the shared tile type.
  localparam int ACC_W_P = 32;

  // Number of tile triples the input buffer can hold.
  localparam int FIFO_DEPTH = 2;

  // Output-transform matrix A^T for F(2x2,3x3). Only 0/+1/-1 appear, so the
  // datapath applies it with adders/subtractors rather than multipliers.
  localparam int AT_COEF [0:1][0:3] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  // Channel index within a tile triple (0..2).
  typedef logic [1:0] ch_idx_t;

  // 4x4 transform-domain accumulator tile, element [row][col].
  typedef logic [0:3][0:3][ACC_W_P-1:0] tile_t;

endpackage
`default_nettype wire

// File: rtl/posta_sat_round.sv
`default_nettype none
// ============================================================================
// Module   : posta_sat_round
// Purpose  : Requantise one wide signed value: optional round-half-up right
//            shift by SHIFT, then saturate to a signed DATA_W result.
// Ports    : din  - IN_W-bit signed input
//            dout - DATA_W-bit signed output (two's complement)
// Revision : 1.0  initial release
// ============================================================================
module posta_sat_round #(
  parameter int IN_W   = 36,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic signed [IN_W-1:0]   din,
  output logic        [DATA_W-1:0] dout
);

  // Limits expressed one bit wider than the input so the rounding add
  // below can never wrap.
  localparam logic signed [IN_W:0] MAX_V =
    {{(IN_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V =
    {{(IN_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [IN_W:0] shifted;

  if (SHIFT > 0) begin : g_round
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
    logic signed [IN_W:0] biased;
    assign biased  = {din[IN_W-1], din} + HALF;
    assign shifted = biased >>> SHIFT;
  end else begin : g_pass
    assign shifted = {din[IN_W-1], din};
  end

  always_comb begin
    dout = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      dout = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[DATA_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/posta_tile_unit.sv
`default_nettype none
// ============================================================================
// Module   : posta_tile_unit
// Purpose  : Winograd F(2x2,3x3) post-transform Y = A^T*U*A for three
//            channels per tile triple. 2-entry input buffer, stage 1 does the
//            row pass (A^T*U), stage 2 the column pass (*A) plus requant, and
//            results stream out one channel per cycle over valid/ready.
// Ports    : clk, rst_n        - clock, async active-low reset
//            valid_in          - tile triple strobe (no backpressure upstream)
//            u0_in/u1_in/u2_in - 4x4 accumulator tiles, channels 0..2
//            in_ready          - input buffer has a free entry
//            out_valid/out_ready, y_out, out_ch, out_last - output stream
//            overflow_err      - sticky: a tile arrived while buffer full
// Revision : 1.0  initial release
// ============================================================================
module posta_tile_unit
  import posta_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [0:3][0:3][ACC_W-1:0]     u0_in,
  input  logic [0:3][0:3][ACC_W-1:0]     u1_in,
  input  logic [0:3][0:3][ACC_W-1:0]     u2_in,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [0:1][0:1][DATA_W-1:0]    y_out,
  output logic [1:0]                     out_ch,
  output logic                           out_last,
  output logic                           overflow_err
);

  // Four guard bits: row pass sums at most 3 terms, column pass 3 more.
  localparam int WIDE  = ACC_W + 4;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef logic [0:3][0:3][ACC_W-1:0] acc_tile_t;

  function automatic logic signed [WIDE-1:0] sext(input logic [ACC_W-1:0] x);
    return {{4{x[ACC_W-1]}}, x};
  endfunction

  // Dot product of one A^T row with a 4-vector.
  function automatic logic signed [WIDE-1:0] at_dot(
    input int                     row,
    input logic signed [WIDE-1:0] a0,
    input logic signed [WIDE-1:0] a1,
    input logic signed [WIDE-1:0] a2,
    input logic signed [WIDE-1:0] a3
  );
    logic signed [WIDE-1:0] v [4];
    logic signed [WIDE-1:0] s;
    v = '{a0, a1, a2, a3};
    s = '0;
    for (int k = 0; k < 4; k++) begin
      if (AT_COEF[row][k] > 0) begin
        s = s + v[k];
      end else if (AT_COEF[row][k] < 0) begin
        s = s - v[k];
      end
    end
    return s;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- FIFO
  acc_tile_t        fifo_u0 [FIFO_DEPTH];
  acc_tile_t        fifo_u1 [FIFO_DEPTH];
  acc_tile_t        fifo_u2 [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             stall;

  ch_idx_t          ch_idx;

  assign in_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign stall      = out_valid && !out_ready;
  assign push       = valid_in && in_ready;
  // The entry is released as its last channel enters stage 1.
  assign pop        = !stall && !fifo_empty && (ch_idx == 2'd2);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_u0[tail] <= u0_in;
      fifo_u1[tail] <= u1_in;
      fifo_u2[tail] <= u2_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (valid_in && !in_ready) overflow_err <= 1'b1;
    end
  end

  // ---------------------------------------------------- stage 1: A^T * U
  acc_tile_t              sel_tile;
  logic signed [WIDE-1:0] m_next [0:1][0:3];
  logic signed [WIDE-1:0] s1_m   [0:1][0:3];
  ch_idx_t                s1_ch;
  logic                   s1_last;
  logic                   s1_valid;

  always_comb begin
    case (ch_idx)
      2'd1:    sel_tile = fifo_u1[head];
      2'd2:    sel_tile = fifo_u2[head];
      default: sel_tile = fifo_u0[head];
    endcase
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        m_next[r][c] = at_dot(r, sext(sel_tile[0][c]), sext(sel_tile[1][c]),
                                 sext(sel_tile[2][c]), sext(sel_tile[3][c]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && !fifo_empty) s1_m <= m_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx   <= '0;
      s1_ch    <= '0;
      s1_last  <= 1'b0;
      s1_valid <= 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        s1_valid <= 1'b1;
        s1_ch    <= ch_idx;
        s1_last  <= (ch_idx == 2'd2);
        ch_idx   <= (ch_idx == 2'd2) ? 2'd0 : ch_idx + 2'd1;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ------------------------------------------- stage 2: M * A + requant
  logic signed [WIDE-1:0] y_wide [0:1][0:1];
  logic [DATA_W-1:0]      y_sat  [0:1][0:1];

  // Y = M * A, so column j of Y uses row j of A^T.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 2; j++) begin
        y_wide[r][j] = at_dot(j, s1_m[r][0], s1_m[r][1], s1_m[r][2], s1_m[r][3]);
      end
    end
  end

  for (genvar r = 0; r < 2; r++) begin : g_row
    for (genvar j = 0; j < 2; j++) begin : g_col
      posta_sat_round #(
        .IN_W   (WIDE),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
      ) u_sat (
        .din  (y_wide[r][j]),
        .dout (y_sat[r][j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      out_ch    <= s1_ch;
      out_last  <= s1_last;
      for (int r = 0; r < 2; r++) begin
        for (int j = 0; j < 2; j++) begin
          y_out[r][j] <= y_sat[r][j];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posta_tile_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_posta_tile_unit
// Purpose  : Self-checking bench for posta_tile_unit (SHIFT=2): table of
//            single-tile vectors with hand-derived results, directed
//            back-to-back / backpressure / mid-operation reset sequences, and
//            random traffic against a matrix-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_posta_tile_unit;
  import posta_pkg::*;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SH = 2;

  // Independent copy of A^T for the reference model.
  localparam int AT_B [0:1][0:3] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      valid_in;
  tile_t                     u0, u1, u2;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:1][0:1][DW-1:0]   y_out;
  logic [1:0]                out_ch;
  logic                      out_last;
  logic                      overflow_err;

  posta_tile_unit #(.DATA_W(DW), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .u0_in        (u0),
    .u1_in        (u1),
    .u2_in        (u2),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .y_out        (y_out),
    .out_ch       (out_ch),
    .out_last     (out_last),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y [4];
    int ch;
    bit last;
  } exp_t;

  typedef struct {
    string  name;
    longint fill;
    longint u00;
    int     e [4];
  } vec_t;

  exp_t sb [$];
  vec_t vecs [8];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  int   hs_count = 0;
  int   low_run = 0;
  int   max_low = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic int requant(input longint v);
    longint t;
    t = v;
    if (SH > 0) t = (t + (longint'(1) <<< (SH-1))) >>> SH;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  // Y = A^T * U * A computed with plain matrix arithmetic.
  function automatic exp_t model(input tile_t t, input int ch);
    longint m [2][4];
    longint v;
    exp_t   e;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        m[r][c] = 0;
        for (int k = 0; k < 4; k++) m[r][c] += AT_B[r][k] * longint'($signed(t[k][c]));
      end
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 2; j++) begin
        v = 0;
        for (int k = 0; k < 4; k++) v += m[r][k] * AT_B[j][k];
        e.y[r*2+j] = requant(v);
      end
    e.ch   = ch;
    e.last = (ch == 2);
    return e;
  endfunction

  function automatic logic [63:0] pack_y(input int y0, input int y1, input int y2, input int y3);
    return {16'(y0), 16'(y1), 16'(y2), 16'(y3)};
  endfunction

  function automatic tile_t mk_tile(input longint fill, input longint u00);
    tile_t t;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) t[k][c] = 32'(fill);
    t[0][0] = 32'(u00);
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        t[k][c] = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                              : 32'(int'($urandom_range(0, 65535)) - 32768);
    return t;
  endfunction

  // Scoreboard step: called once per cycle just after the falling edge,
  // while inputs and registered outputs are both stable.
  task automatic monitor();
    exp_t e;
    if (!mon_en) return;
    if (!in_ready) low_run++;
    else low_run = 0;
    if (low_run > max_low) max_low = low_run;
    if (valid_in && in_ready) begin
      sb.push_back(model(u0, 0));
      sb.push_back(model(u1, 1));
      sb.push_back(model(u2, 2));
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = sb[0];
        chk("sb_y_out", y_out, pack_y(e.y[0], e.y[1], e.y[2], e.y[3]));
        chk("sb_ch_last", {out_ch, out_last}, {e.ch[1:0], e.last});
        if (out_ready) begin
          e = sb.pop_front();
          hs_count++;
        end
      end
    end
  endtask

  task automatic cyc();
    monitor();
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    valid_in  = 1'b0;
    for (int n = 0; n < 200 && (sb.size() != 0 || out_valid); n++) cyc();
    chk({nm, "_drained"}, 64'(sb.size()), 64'(0));
  endtask

  // One tile (same on all three channels), out_ready held high.
  task automatic run_vec(input vec_t v);
    tile_t t;
    int    got;
    t = mk_tile(v.fill, v.u00);
    u0 = t; u1 = t; u2 = t;
    out_ready = 1'b1;
    valid_in  = 1'b1;
    cyc();
    valid_in = 1'b0;
    got = 0;
    for (int n = 1; n <= 20 && got < 3; n++) begin
      if (out_valid) begin
        if (got == 0) chk({v.name, "_latency"}, 64'(n), 64'(3));
        chk({v.name, "_y"}, y_out, pack_y(v.e[0], v.e[1], v.e[2], v.e[3]));
        chk({v.name, "_ch_last"}, {out_ch, out_last}, {2'(got), 1'(got == 2)});
        got++;
      end
      cyc();
    end
    chk({v.name, "_count"}, 64'(got), 64'(3));
    chk({v.name, "_idle"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   cnt;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    u0 = '0; u1 = '0; u2 = '0;

    vecs[0] = '{name: "ones",    fill: 1, u00: 1,          e: '{2, -1, -1, 0}};
    vecs[1] = '{name: "twos",    fill: 2, u00: 2,          e: '{5, -1, -1, 1}};
    vecs[2] = '{name: "sat_pos", fill: 0, u00: 1048576,    e: '{32767, 0, 0, 0}};
    vecs[3] = '{name: "sat_neg", fill: 0, u00: -1048576,   e: '{-32768, 0, 0, 0}};
    vecs[4] = '{name: "rnd_p6",  fill: 0, u00: 6,          e: '{2, 0, 0, 0}};
    vecs[5] = '{name: "rnd_m6",  fill: 0, u00: -6,         e: '{-1, 0, 0, 0}};
    vecs[6] = '{name: "rnd_p5",  fill: 0, u00: 5,          e: '{1, 0, 0, 0}};
    vecs[7] = '{name: "edge_lo", fill: 0, u00: -131074,    e: '{-32768, 0, 0, 0}};

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y_out", y_out, 64'(0));
    chk("rst_ch_last", {out_ch, out_last}, 64'(0));
    chk("rst_overflow", 64'(overflow_err), 64'(0));
    rst_n = 1'b1;
    cyc();
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: one tile every 4 cycles, consumer always ready.
    mon_en = 1'b1; hs_count = 0; max_low = 0; low_run = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u0 = rand_tile(); u1 = rand_tile(); u2 = rand_tile();
      valid_in = 1'b1;
      cyc();
      valid_in = 1'b0;
      repeat (3) cyc();
    end
    drain("b2b");
    chk("b2b_outputs", 64'(hs_count), 64'(12));
    chk("b2b_overflow", 64'(overflow_err), 64'(0));
    chk("b2b_in_ready_low_run", 64'(max_low <= 1), 64'(1));

    // Backpressure: three consecutive tiles with the consumer stalled.
    hs_count = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u0 = rand_tile(); u1 = rand_tile(); u2 = rand_tile();
      valid_in = 1'b1;
      cyc();
    end
    valid_in = 1'b0;
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_overflow", 64'(overflow_err), 64'(1));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    repeat (5) cyc();
    drain("bp");
    chk("bp_outputs", 64'(hs_count), 64'(6));

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      u0 = rand_tile(); u1 = rand_tile(); u2 = rand_tile();
      valid_in  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain("rand");

    // Reset while channel 1 of a tile is still in the pipe.
    mon_en = 1'b0;
    sb.delete();
    out_ready = 1'b0;
    u0 = mk_tile(1, 1); u1 = u0; u2 = u0;
    valid_in = 1'b1;
    cyc();
    valid_in = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) cyc();
    chk("rmid_wait_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rmid_out_valid", 64'(out_valid), 64'(0));
    chk("rmid_y_out", y_out, 64'(0));
    chk("rmid_ch_last", {out_ch, out_last}, 64'(0));
    chk("rmid_overflow", 64'(overflow_err), 64'(0));
    chk("rmid_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (out_valid) cnt++;
      cyc();
    end
    chk("rmid_no_stale", 64'(cnt), 64'(0));
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
